// File: rtl/pattern_dac_burst_if.sv
// Configuration/status bundle for pattern_dac_burst.
// The master side drives the burst request and settings; the slave side returns the DAC code and burst status.
interface pattern_dac_burst_if #(
  parameter int unsigned PAT_W = 32,
  parameter int unsigned DAC_W = 14,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             stop;
  logic [PAT_W-1:0] pat;
  logic [7:0]       pat_len;
  logic [CNT_W-1:0] bit_hold;
  logic [CNT_W-1:0] gap;
  logic [7:0]       burst_num;
  logic [DAC_W-1:0] dac_hi;
  logic [DAC_W-1:0] dac_lo;
  logic             pwm_out;
  logic [DAC_W-1:0] dac_data;
  logic             busy;
  logic             done;
  logic [7:0]       burst_cnt;

  modport master (
    output start, stop, pat, pat_len, bit_hold, gap, burst_num, dac_hi, dac_lo,
    input  pwm_out, dac_data, busy, done, burst_cnt
  );

  modport slave (
    input  start, stop, pat, pat_len, bit_hold, gap, burst_num, dac_hi, dac_lo,
    output pwm_out, dac_data, busy, done, burst_cnt
  );
endinterface

// File: rtl/pattern_dac_burst.sv
// Serial pattern burst generator: replays a latched bit pattern with per-bit hold and
// inter-pattern gaps, and maps each bit to a DAC code one cycle later.
module pattern_dac_burst #(
  parameter int unsigned PAT_W = 32,
  parameter int unsigned DAC_W = 14,
  parameter int unsigned CNT_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  pattern_dac_burst_if.slave bus
);
  localparam int unsigned BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [PAT_W-1:0] r_pat;
  logic [BIT_W-1:0] r_last;
  logic [CNT_W-1:0] r_hold_max;
  logic [CNT_W-1:0] r_gap_len;
  logic [7:0]       r_burst_num;
  logic [DAC_W-1:0] r_dac_hi;
  logic [DAC_W-1:0] r_dac_lo;
  logic [BIT_W-1:0] r_bit;
  logic [CNT_W-1:0] r_hold;
  logic [CNT_W-1:0] r_gap_cnt;
  logic             r_stop_pend;
  logic             r_pwm;
  logic [DAC_W-1:0] r_dac;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_burst_cnt;

  logic             w_accept;
  logic             w_hold_end;
  logic             w_pat_end;
  logic             w_gap_end;
  logic             w_end_burst;
  logic [7:0]       w_cnt_inc;
  logic [BIT_W-1:0] w_last_in;
  logic [PAT_W-1:0] w_pat_src;

  logic [BIT_W-1:0] w_bit_nxt;
  logic [CNT_W-1:0] w_hold_nxt;
  logic [CNT_W-1:0] w_gap_cnt_nxt;
  logic [7:0]       w_cnt_nxt;
  logic             w_pend_nxt;
  logic             w_pwm_nxt;
  logic [DAC_W-1:0] w_dac_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  // Lengths of 0 or beyond the register width replay the whole register.
  assign w_last_in = ((bus.pat_len == 8'd0) || (32'(bus.pat_len) > PAT_W))
                     ? BIT_W'(PAT_W - 1) : BIT_W'(bus.pat_len - 8'd1);

  assign w_accept    = (r_state == S_IDLE) && bus.start;
  assign w_hold_end  = (r_hold == r_hold_max);
  assign w_pat_end   = (r_bit == r_last);
  assign w_gap_end   = (r_gap_cnt == (r_gap_len - CNT_W'(1)));
  assign w_cnt_inc   = (r_burst_cnt == 8'hFF) ? 8'hFF : (r_burst_cnt + 8'd1);
  assign w_end_burst = ((r_burst_num != 8'd0) && (w_cnt_inc == r_burst_num))
                       || r_stop_pend || bus.stop;
  assign w_pat_src   = w_accept ? bus.pat : r_pat;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_hold_end && w_pat_end) begin
          if (w_end_burst)              w_state_nxt = S_DONE;
          else if (r_gap_len != '0)     w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (bus.stop)       w_state_nxt = S_DONE;
        else if (w_gap_end) w_state_nxt = S_RUN;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counter and output next values; everything lands in registers below.
  always_comb begin
    w_bit_nxt     = r_bit;
    w_hold_nxt    = r_hold;
    w_gap_cnt_nxt = '0;
    w_cnt_nxt     = r_burst_cnt;
    w_pend_nxt    = r_stop_pend;
    case (r_state)
      S_IDLE: begin
        w_bit_nxt  = '0;
        w_hold_nxt = '0;
        w_pend_nxt = 1'b0;
        if (bus.start) w_cnt_nxt = '0;
      end
      S_RUN: begin
        if (bus.stop) w_pend_nxt = 1'b1;
        if (w_hold_end) begin
          w_hold_nxt = '0;
          w_bit_nxt  = w_pat_end ? '0 : (r_bit + BIT_W'(1));
          if (w_pat_end) w_cnt_nxt = w_cnt_inc;
        end else begin
          w_hold_nxt = r_hold + CNT_W'(1);
        end
      end
      S_GAP: begin
        w_bit_nxt     = '0;
        w_hold_nxt    = '0;
        w_gap_cnt_nxt = r_gap_cnt + CNT_W'(1);
      end
      S_DONE: begin
        w_bit_nxt  = '0;
        w_hold_nxt = '0;
        w_pend_nxt = 1'b0;
      end
      default: begin
        w_bit_nxt  = '0;
        w_hold_nxt = '0;
        w_pend_nxt = 1'b0;
      end
    endcase
    w_pwm_nxt  = (w_state_nxt == S_RUN) ? w_pat_src[w_bit_nxt] : 1'b0;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
    // The code lags pwm by one cycle; a fresh start already uses the new low code.
    w_dac_nxt  = r_pwm ? r_dac_hi : (w_accept ? bus.dac_lo : r_dac_lo);
  end

  // Latched configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat       <= '0;
      r_last      <= '0;
      r_hold_max  <= '0;
      r_gap_len   <= '0;
      r_burst_num <= '0;
      r_dac_hi    <= '0;
      r_dac_lo    <= '0;
    end else if (w_accept) begin
      r_pat       <= bus.pat;
      r_last      <= w_last_in;
      r_hold_max  <= bus.bit_hold;
      r_gap_len   <= bus.gap;
      r_burst_num <= bus.burst_num;
      r_dac_hi    <= bus.dac_hi;
      r_dac_lo    <= bus.dac_lo;
    end
  end

  // Counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit       <= '0;
      r_hold      <= '0;
      r_gap_cnt   <= '0;
      r_burst_cnt <= '0;
      r_stop_pend <= 1'b0;
      r_pwm       <= 1'b0;
      r_dac       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_bit       <= w_bit_nxt;
      r_hold      <= w_hold_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_burst_cnt <= w_cnt_nxt;
      r_stop_pend <= w_pend_nxt;
      r_pwm       <= w_pwm_nxt;
      r_dac       <= w_dac_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign bus.pwm_out   = r_pwm;
  assign bus.dac_data  = r_dac;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.burst_cnt = r_burst_cnt;
endmodule

// File: doc/pattern_dac_burst.md
PATTERN_DAC_BURST -- requirements
Module: pattern_dac_burst

Interface
REQ-001 SHALL have parameter PAT_W, default 32: pattern register width in bits.
REQ-002 SHALL have parameter DAC_W, default 14: DAC code width.
REQ-003 SHALL have parameter CNT_W, default 16: width of the bit_hold and gap counters.
REQ-004 SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async reset, active low
- start  in  1  single-cycle start request
- stop  in  1  single-cycle graceful stop request
- pat  in  PAT_W  pattern; bit 0 is emitted first
- pat_len  in  8  pattern length in bits
- bit_hold  in  CNT_W  extra cycles each bit is held
- gap  in  CNT_W  idle cycles between patterns
- burst_num  in  8  number of patterns; 0 means infinite
- dac_hi  in  DAC_W  code output for bit=1
- dac_lo  in  DAC_W  code output for bit=0
- pwm_out  out  1  current pattern bit
- dac_data  out  DAC_W  registered DAC code
- busy  out  1  burst in progress
- done  out  1  single-cycle end-of-burst pulse
- burst_cnt  out  8  patterns completed in the current burst

Function
REQ-006 States SHALL be IDLE, RUN, GAP and DONE; the state after reset SHALL be IDLE.
REQ-007 In IDLE, start=1 SHALL latch pat, pat_len, bit_hold, gap, burst_num, dac_hi and dac_lo, clear burst_cnt, and enter RUN with pwm_out=pat[0] on the next cycle.
REQ-008 Inputs other than stop SHALL be ignored while busy; start SHALL be ignored outside IDLE.
REQ-009 Effective length L SHALL be PAT_W when the latched pat_len is 0 or greater than PAT_W, and pat_len otherwise.
REQ-010 In RUN, each bit SHALL be held bit_hold+1 cycles; bits 0..L-1 SHALL be emitted in order, so one pattern lasts L*(bit_hold+1) cycles.
REQ-011 After the last bit of a pattern, burst_cnt SHALL increment, saturating at 255.
REQ-012 The burst SHALL end when burst_num is nonzero and burst_cnt reaches burst_num.
REQ-013 The burst SHALL also end when a stop is pending.
REQ-014 When the burst ends, the next state SHALL be DONE.
REQ-015 After the last bit of a pattern, when the burst has not ended, the next state SHALL be GAP if gap>0, else RUN restarting at bit 0.
REQ-016 GAP SHALL last exactly gap cycles with pwm_out=0, then return to RUN with pwm_out=pat[0].
REQ-017 A stop pulse in RUN SHALL be recorded as pending; the current pattern SHALL complete and its gap SHALL be skipped.
REQ-018 A stop pulse in GAP SHALL enter DONE on the next cycle.
REQ-019 The pending stop SHALL clear in DONE; stop in IDLE SHALL have no effect.
REQ-020 DONE SHALL last one cycle with pwm_out=0 and done=1, then return to IDLE.
REQ-021 busy SHALL be 1 from the first RUN cycle through the DONE cycle inclusive, and 0 otherwise.
REQ-022 dac_data SHALL equal dac_hi when pwm_out was 1 in the previous cycle, else dac_lo, giving a fixed 1-cycle lag behind pwm_out.
REQ-023 In IDLE, dac_data SHALL use the most recently latched dac_lo.
REQ-024 The bit counter SHALL cover values up to PAT_W-1; the hold and gap counters SHALL be CNT_W bits with no wrap beyond the programmed value.
REQ-025 If start and stop arrive in the same IDLE cycle, start SHALL win and stop SHALL be discarded.

Reset
REQ-026 rst_n low SHALL, asynchronously and in any state, force state=IDLE.
REQ-027 rst_n low SHALL force pwm_out=0, dac_data=0, busy=0, done=0 and burst_cnt=0.
REQ-028 rst_n low SHALL clear the pending stop and all counters, and the latched dac_lo SHALL reset to 0.
REQ-029 Operation after reset release SHALL require a new start.

Verification
REQ-030 Finite burst:
- stimulus: PAT_W=8, pat=0x05, pat_len=3, bit_hold=1, gap=2, burst_num=2, dac_hi=0x3FFF, dac_lo=0, start at cycle 0.
- pwm_out, cycles 1-15: 1,1,0,0,1,1,0,0,1,1,0,0,1,1,0.
- done=1 only at cycle 15; busy=1 for cycles 1-15; burst_cnt=2.
- dac_data mirrors pwm_out delayed by one cycle.
REQ-031 Infinite mode with stop:
- stimulus: burst_num=0, same pattern, stop pulsed at cycle 4.
- response: the first pattern completes at cycle 6 and the gap is skipped.
- DONE at cycle 7; burst_cnt=1.
REQ-032 Length clamp:
- stimulus: pat_len=0, PAT_W=8, pat=0xFF, bit_hold=0, gap=0, burst_num=1.
- response: pwm_out=1 for exactly 8 cycles, then DONE.
REQ-033 Start while busy:
- stimulus: second start with different pat at cycle 3 of the scenario in REQ-030.
- response: output identical to REQ-030.
REQ-034 Reset mid-burst:
- stimulus: rst_n low at cycle 5 of the scenario in REQ-030.
- response: all outputs are 0 in the same cycle with no done pulse.
- a new start after release reproduces REQ-030.
REQ-035 Stop in GAP:
- stimulus: gap=5, burst_num=3, stop at the second GAP cycle.
- response: DONE on the next cycle; burst_cnt=1.
